// File: rtl/register_file_mp.sv
// Multi-port register file: register 0 hard-wired to zero, highest write port wins,
// optional write-to-read bypass, and a sequenced clear that walks registers 1..DEPTH-1.
module register_file_mp #(
  parameter int WIDTH  = 32,
  parameter int DEPTH  = 32,
  parameter int NUM_RD = 2,
  parameter int NUM_WR = 2,
  parameter int BYPASS = 1,
  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_WR-1:0]        wr_en,
  input  logic [NUM_WR*AW-1:0]     wr_addr,
  input  logic [NUM_WR*WIDTH-1:0]  wr_data,
  input  logic [NUM_RD*AW-1:0]     rd_addr,
  output logic [NUM_RD*WIDTH-1:0]  rd_data,
  input  logic                     clr_req,
  output logic                     clr_busy,
  output logic                     clr_done,
  output logic                     wr_conflict
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CLEAR = 2'd1,
    ST_DONE  = 2'd2
  } clr_state_t;

  clr_state_t        state_r;
  logic [AW-1:0]     cnt_r;
  logic [WIDTH-1:0]  mem_r    [DEPTH];

  logic [AW-1:0]     wa_s     [NUM_WR];
  logic [WIDTH-1:0]  wd_s     [NUM_WR];
  logic [NUM_WR-1:0] wr_req_s;
  logic [NUM_WR-1:0] wr_ok_s;
  logic              conflict_s;
  logic [WIDTH-1:0]  rd_val_s [NUM_RD];

  // Address 0 and anything beyond the array are never stored.
  function automatic logic addr_ok(input logic [AW-1:0] a);
    return (32'(a) < 32'(DEPTH)) && (a != {AW{1'b0}});
  endfunction

  // Unpack write ports; external writes are suppressed while a clear is running.
  always_comb begin
    for (int p = 0; p < NUM_WR; p++) begin
      wa_s[p]     = wr_addr[p*AW +: AW];
      wd_s[p]     = wr_data[p*WIDTH +: WIDTH];
      wr_req_s[p] = wr_en[p] & ~clr_busy;
      wr_ok_s[p]  = wr_req_s[p] & addr_ok(wa_s[p]);
    end
  end

  // Any pair of live write ports aimed at the same nonzero address.
  always_comb begin
    conflict_s = 1'b0;
    for (int p = 0; p < NUM_WR; p++) begin
      for (int q = p + 1; q < NUM_WR; q++) begin
        conflict_s = conflict_s | (wr_req_s[p] & wr_req_s[q] &
                                   (wa_s[p] == wa_s[q]) & (wa_s[p] != {AW{1'b0}}));
      end
    end
  end

  // Read mux; ascending port scan lets the highest matching writer override the stored value.
  always_comb begin
    for (int r = 0; r < NUM_RD; r++) begin
      rd_val_s[r] = addr_ok(rd_addr[r*AW +: AW]) ? mem_r[rd_addr[r*AW +: AW]] : {WIDTH{1'b0}};
      for (int p = 0; p < NUM_WR; p++) begin
        rd_val_s[r] = ((BYPASS != 0) && wr_ok_s[p] && (wa_s[p] == rd_addr[r*AW +: AW]))
                      ? wd_s[p] : rd_val_s[r];
      end
    end
  end

  // Pack read results onto the output bus.
  always_comb begin
    rd_data = {NUM_RD*WIDTH{1'b0}};
    for (int r = 0; r < NUM_RD; r++) begin
      rd_data[r*WIDTH +: WIDTH] = rd_val_s[r];
    end
  end

  // Storage: later (higher) ports in the loop override earlier ones at the same address.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= {WIDTH{1'b0}};
      end
    end else begin
      if (state_r == ST_CLEAR) begin
        mem_r[cnt_r] <= {WIDTH{1'b0}};
      end
      for (int p = 0; p < NUM_WR; p++) begin
        if (wr_ok_s[p]) begin
          mem_r[wa_s[p]] <= wd_s[p];
        end
      end
    end
  end

  // Clear sequencer with registered busy/done flags.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_r  <= ST_IDLE;
      cnt_r    <= {AW{1'b0}};
      clr_busy <= 1'b0;
      clr_done <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          clr_done <= 1'b0;
          if (clr_req) begin
            cnt_r    <= AW'(1);
            state_r  <= ST_CLEAR;
            clr_busy <= 1'b1;
          end
        end
        ST_CLEAR: begin
          if (cnt_r == AW'(DEPTH - 1)) begin
            state_r  <= ST_DONE;
            clr_busy <= 1'b0;
            clr_done <= 1'b1;
          end else begin
            cnt_r <= cnt_r + 1'b1;
          end
        end
        ST_DONE: begin
          clr_done <= 1'b0;
          state_r  <= ST_IDLE;
        end
        default: begin
          state_r  <= ST_IDLE;
          clr_busy <= 1'b0;
          clr_done <= 1'b0;
        end
      endcase
    end
  end

  // Conflict flag reflects the previous cycle's write pattern.
  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_conflict <= 1'b0;
    end else begin
      wr_conflict <= conflict_s;
    end
  end

endmodule

// File: tb/tb_register_file_mp.sv
// Directed bench: vector table for the 32-deep bypassing build, hand sequences for clear,
// mid-clear reset, and a 24-deep non-bypassing build.
module tb_register_file_mp;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  wr_en;
  logic [9:0]  wr_addr, rd_addr;
  logic [63:0] wr_data, rd_data;
  logic        clr_req, clr_busy, clr_done, wr_conflict;

  logic [1:0]  b_wr_en;
  logic [9:0]  b_wr_addr, b_rd_addr;
  logic [63:0] b_wr_data, b_rd_data;
  logic        b_clr_req, b_clr_busy, b_clr_done, b_wr_conflict;

  int checks = 0;
  int errors = 0;

  register_file_mp dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_addr(rd_addr), .rd_data(rd_data), .clr_req(clr_req), .clr_busy(clr_busy),
    .clr_done(clr_done), .wr_conflict(wr_conflict)
  );

  register_file_mp #(.DEPTH(24), .BYPASS(0)) dut_b (
    .clk(clk), .rst(rst), .wr_en(b_wr_en), .wr_addr(b_wr_addr), .wr_data(b_wr_data),
    .rd_addr(b_rd_addr), .rd_data(b_rd_data), .clr_req(b_clr_req), .clr_busy(b_clr_busy),
    .clr_done(b_clr_done), .wr_conflict(b_wr_conflict)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  en;
    logic [4:0]  a0, a1;
    logic [31:0] d0, d1;
    logic [4:0]  r0, r1;
    logic [31:0] e0, e1;
    logic        ec;
  } vec_t;

  vec_t vt [13];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    vt[0]  = '{2'b00, 5'd0,  5'd0,  32'h0,        32'h0,        5'd5,  5'd0,  32'h0,        32'h0,        1'b0};
    vt[1]  = '{2'b01, 5'd5,  5'd0,  32'hDEADBEEF, 32'h0,        5'd5,  5'd0,  32'hDEADBEEF, 32'h0,        1'b0};
    vt[2]  = '{2'b00, 5'd0,  5'd0,  32'h0,        32'h0,        5'd5,  5'd0,  32'hDEADBEEF, 32'h0,        1'b0};
    vt[3]  = '{2'b11, 5'd7,  5'd7,  32'h11111111, 32'h22222222, 5'd7,  5'd5,  32'h22222222, 32'hDEADBEEF, 1'b1};
    vt[4]  = '{2'b00, 5'd0,  5'd0,  32'h0,        32'h0,        5'd7,  5'd7,  32'h22222222, 32'h22222222, 1'b0};
    vt[5]  = '{2'b01, 5'd3,  5'd0,  32'hCAFEF00D, 32'h0,        5'd4,  5'd3,  32'h0,        32'hCAFEF00D, 1'b0};
    vt[6]  = '{2'b11, 5'd0,  5'd0,  32'h0000AAAA, 32'h0000BBBB, 5'd0,  5'd3,  32'h0,        32'hCAFEF00D, 1'b0};
    vt[7]  = '{2'b11, 5'd10, 5'd11, 32'h1,        32'h2,        5'd10, 5'd11, 32'h1,        32'h2,        1'b0};
    vt[8]  = '{2'b10, 5'd12, 5'd13, 32'h55,       32'h66,       5'd12, 5'd13, 32'h0,        32'h66,       1'b0};
    vt[9]  = '{2'b11, 5'd31, 5'd1,  32'h777,      32'h888,      5'd31, 5'd1,  32'h777,      32'h888,      1'b0};
    vt[10] = '{2'b00, 5'd0,  5'd0,  32'h0,        32'h0,        5'd10, 5'd13, 32'h1,        32'h66,       1'b0};
    vt[11] = '{2'b11, 5'd0,  5'd6,  32'h12345678, 32'h99,       5'd0,  5'd6,  32'h0,        32'h99,       1'b0};
    vt[12] = '{2'b11, 5'd20, 5'd20, 32'h5,        32'h6,        5'd20, 5'd6,  32'h6,        32'h99,       1'b1};

    rst = 1'b0; clr_req = 1'b0; wr_en = 2'b00; wr_addr = 10'd0; wr_data = 64'd0; rd_addr = 10'd0;
    b_clr_req = 1'b0; b_wr_en = 2'b00; b_wr_addr = 10'd0; b_wr_data = 64'd0; b_rd_addr = 10'd0;
    step(); step();
    chk("rst_busy", {31'd0, clr_busy}, 32'd0);
    chk("rst_done", {31'd0, clr_done}, 32'd0);
    chk("rst_conflict", {31'd0, wr_conflict}, 32'd0);
    rst = 1'b1;

    for (int i = 0; i < 13; i++) begin
      wr_en   = vt[i].en;
      wr_addr = {vt[i].a1, vt[i].a0};
      wr_data = {vt[i].d1, vt[i].d0};
      rd_addr = {vt[i].r1, vt[i].r0};
      #1;
      chk($sformatf("v%0d_rd0", i), rd_data[31:0], vt[i].e0);
      chk($sformatf("v%0d_rd1", i), rd_data[63:32], vt[i].e1);
      step();
      chk($sformatf("v%0d_conflict", i), {31'd0, wr_conflict}, {31'd0, vt[i].ec});
    end
    wr_en = 2'b00;
    rd_addr = {5'd20, 5'd0};
    #1;
    chk("hi_port_wins", rd_data[63:32], 32'h6);

    // Fill 1..31 with the pattern, then run a full clear.
    for (int a = 1; a < 32; a += 2) begin
      wr_en = 2'b11;
      wr_addr = {5'(a + 1), 5'(a)};
      wr_data = {32'hA5A5A5A5, 32'hA5A5A5A5};
      step();
    end
    wr_en = 2'b00;
    rd_addr = {5'd31, 5'd1};
    #1;
    chk("fill_r1", rd_data[31:0], 32'hA5A5A5A5);
    chk("fill_r31", rd_data[63:32], 32'hA5A5A5A5);

    clr_req = 1'b1;
    step();
    clr_req = 1'b0;
    n = 0;
    while (clr_busy === 1'b1 && n < 100) begin
      n++;
      wr_en = 2'b00;
      if (n == 5) begin
        wr_en = 2'b11;
        wr_addr = {5'd9, 5'd9};
        wr_data = {32'h99, 32'h98};
        rd_addr = {5'd9, 5'd9};
        #1;
        chk("busy_no_bypass", rd_data[31:0], 32'hA5A5A5A5);
      end
      if (n == 6) chk("busy_no_conflict", {31'd0, wr_conflict}, 32'd0);
      clr_req = (n == 8);
      step();
    end
    clr_req = 1'b0;
    wr_en = 2'b00;
    chk("clear_busy_cycles", 32'(n), 32'd31);
    chk("clear_done_pulse", {31'd0, clr_done}, 32'd1);
    step();
    chk("clear_done_low", {31'd0, clr_done}, 32'd0);
    chk("clear_req_not_queued", {31'd0, clr_busy}, 32'd0);
    for (int r = 0; r < 32; r++) begin
      rd_addr = {5'(31 - r), 5'(r)};
      #1;
      chk($sformatf("cleared_r%0d", r), rd_data[31:0] | rd_data[63:32], 32'd0);
    end

    // Reset in the middle of a clear, with a concurrent write.
    wr_en = 2'b11;
    wr_addr = {5'd30, 5'd20};
    wr_data = {32'h6, 32'h5};
    step();
    wr_en = 2'b00;
    clr_req = 1'b1;
    step();
    clr_req = 1'b0;
    repeat (10) step();
    chk("midclr_busy", {31'd0, clr_busy}, 32'd1);
    rst = 1'b0;
    wr_en = 2'b01;
    wr_addr = {5'd0, 5'd25};
    wr_data = {32'h0, 32'h77};
    step();
    chk("midclr_rst_busy", {31'd0, clr_busy}, 32'd0);
    chk("midclr_rst_done", {31'd0, clr_done}, 32'd0);
    rst = 1'b1;
    wr_en = 2'b00;
    rd_addr = {5'd30, 5'd20};
    #1;
    chk("midclr_r20", rd_data[31:0], 32'd0);
    chk("midclr_r30", rd_data[63:32], 32'd0);
    rd_addr = {5'd0, 5'd25};
    #1;
    chk("midclr_r25", rd_data[31:0], 32'd0);
    step();
    chk("midclr_idle", {31'd0, clr_busy}, 32'd0);

    // DEPTH=24, no bypass.
    b_wr_en = 2'b01;
    b_wr_addr = {5'd0, 5'd3};
    b_wr_data = {32'h0, 32'hCAFEF00D};
    b_rd_addr = {5'd3, 5'd0};
    #1;
    chk("b_nobypass_old", b_rd_data[63:32], 32'd0);
    step();
    b_wr_en = 2'b00;
    #1;
    chk("b_after_write", b_rd_data[63:32], 32'hCAFEF00D);
    b_wr_en = 2'b11;
    b_wr_addr = {5'd24, 5'd0};
    b_wr_data = {32'h12345678, 32'h12345678};
    b_rd_addr = {5'd24, 5'd0};
    step();
    b_wr_en = 2'b00;
    #1;
    chk("b_addr0", b_rd_data[31:0], 32'd0);
    chk("b_addr_depth", b_rd_data[63:32], 32'd0);
    b_wr_en = 2'b10;
    b_wr_addr = {5'd23, 5'd0};
    b_wr_data = {32'hBEEF, 32'h0};
    step();
    b_wr_en = 2'b00;
    b_rd_addr = {5'd23, 5'd3};
    #1;
    chk("b_top_reg", b_rd_data[63:32], 32'hBEEF);
    b_clr_req = 1'b1;
    step();
    b_clr_req = 1'b0;
    n = 0;
    while (b_clr_busy === 1'b1 && n < 100) begin
      n++;
      step();
    end
    chk("b_clear_cycles", 32'(n), 32'd23);
    chk("b_clear_done", {31'd0, b_clr_done}, 32'd1);
    #1;
    chk("b_cleared_r3", b_rd_data[31:0], 32'd0);
    chk("b_cleared_r23", b_rd_data[63:32], 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
